// File: rtl/mem_arb_pkg.sv
// Shared encodings for the IF/DM memory port arbiter: FSM states, owner codes, counter widths.
// Pure definitions; no latency or backpressure of its own.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  // Latency counter holds up to MEM_LAT-1 = 3; starvation counter up to STARVE_MAX = 15.
  localparam int LAT_CW    = 2;
  localparam int STARVE_CW = 4;

  localparam logic [2:0] MEM_TYPE_FETCH = 3'd0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  mtype;
  } mem_cmd_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant decision (combinational) plus fairness state update; MEMARB_ROUND_ROBIN_EN selects alternation
// instead of data-priority with starvation guard. Grant is only meaningful when take_i is high.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req_i,
  input  logic dm_req_i,
  input  logic take_i,
  output logic grant_dm_o
);

`ifdef MEMARB_ROUND_ROBIN_EN
  logic last_dm_q, last_dm_d;

  always_comb begin
    grant_dm_o = dm_req_i & (~if_req_i | ~last_dm_q);
    last_dm_d  = last_dm_q;
    if (take_i) begin
      last_dm_d = grant_dm_o;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_dm_q <= OWN_IF;
    end else begin
      last_dm_q <= last_dm_d;
    end
  end
`else
  localparam logic [STARVE_CW-1:0] STARVE_LIM = STARVE_CW'(STARVE_MAX);

  logic [STARVE_CW-1:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    grant_dm_o   = dm_req_i & (~if_req_i | (starve_cnt_q != STARVE_LIM));
    starve_cnt_d = starve_cnt_q;
    if (take_i) begin
      if (!grant_dm_o) begin
        starve_cnt_d = '0;
      end else if (if_req_i && (starve_cnt_q != STARVE_LIM)) begin
        starve_cnt_d = starve_cnt_q + STARVE_CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between IF and DM ports; valid at t+1+MEM_LAT after IDLE sampling.
// One access in flight; requesters hold req until valid, stall_* tell the core to freeze (MEMARB_ROUND_ROBIN_EN optional).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [2:0]  dm_type,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_type,
  input  logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_dm
);

  localparam logic [LAT_CW-1:0] LAT_LOAD = LAT_CW'(MEM_LAT - 1);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic [LAT_CW-1:0] lat_cnt_q, lat_cnt_d;
  mem_cmd_t          cmd_q, cmd_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       dm_rdata_q, dm_rdata_d;
  logic              take;
  logic              grant_dm;

  assign take = (state_q == IDLE) & (if_req | dm_req);

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk        (clk),
    .rst        (rst),
    .if_req_i   (if_req),
    .dm_req_i   (dm_req),
    .take_i     (take),
    .grant_dm_o (grant_dm)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    lat_cnt_d  = lat_cnt_q;
    cmd_d      = cmd_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;

    mem_en   = 1'b0;
    if_valid = 1'b0;
    dm_valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (take) begin
          state_d = ISSUE;
          owner_d = grant_dm ? OWN_DM : OWN_IF;
          if (grant_dm) begin
            cmd_d = '{we: dm_we, addr: dm_addr, wdata: dm_wdata, mtype: dm_type};
          end else begin
            cmd_d = '{we: 1'b0, addr: if_addr, wdata: 32'd0, mtype: MEM_TYPE_FETCH};
          end
        end
      end
      ISSUE: begin
        mem_en = 1'b1;
        if (MEM_LAT == 1) begin
          state_d = DONE;
        end else begin
          lat_cnt_d = LAT_LOAD;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        lat_cnt_d = lat_cnt_q - LAT_CW'(1);
        if (lat_cnt_q == LAT_CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (owner_q == OWN_DM) begin
          dm_valid   = 1'b1;
          dm_rdata_d = mem_rdata;
        end else begin
          if_valid   = 1'b1;
          if_rdata_d = mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read data is forwarded straight from memory in the DONE cycle, then held in the register.
  assign if_rdata  = if_valid ? mem_rdata : if_rdata_q;
  assign dm_rdata  = dm_valid ? mem_rdata : dm_rdata_q;
  assign mem_we    = cmd_q.we;
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;
  assign mem_type  = cmd_q.mtype;
  assign stall_if  = if_req & ~if_valid;
  assign stall_dm  = dm_req & ~dm_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      lat_cnt_q  <= '0;
      cmd_q      <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      lat_cnt_q  <= lat_cnt_d;
      cmd_q      <= cmd_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed MEM_LAT=1 instance plus randomized MEM_LAT=3 instance vs. a schedule model.
// Honours MEMARB_ROUND_ROBIN_EN when predicting grants.
module tb_mem_port_arbiter;

  localparam int LAT  = 3;
  localparam int SMAX = 4;
  localparam int NCYC = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [2:0]  dm_type;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_valid, dm_valid, mem_en, mem_we, stall_if, stall_dm;
  logic [2:0]  mem_type;

  logic        l1_if_req, l1_dm_req, l1_dm_we;
  logic [31:0] l1_if_addr, l1_dm_addr, l1_dm_wdata, l1_mem_rdata;
  logic [2:0]  l1_dm_type;
  logic [31:0] l1_if_rdata, l1_dm_rdata, l1_mem_addr, l1_mem_wdata;
  logic        l1_if_valid, l1_dm_valid, l1_mem_en, l1_mem_we, l1_stall_if, l1_stall_dm;
  logic [2:0]  l1_mem_type;

  mem_port_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_type(dm_type),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_type(mem_type), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_dm(stall_dm)
  );

  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(SMAX)) dut_l1 (
    .clk(clk), .rst(rst),
    .if_req(l1_if_req), .if_addr(l1_if_addr), .if_rdata(l1_if_rdata), .if_valid(l1_if_valid),
    .dm_req(l1_dm_req), .dm_we(l1_dm_we), .dm_addr(l1_dm_addr), .dm_wdata(l1_dm_wdata),
    .dm_type(l1_dm_type), .dm_rdata(l1_dm_rdata), .dm_valid(l1_dm_valid),
    .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
    .mem_type(l1_mem_type), .mem_rdata(l1_mem_rdata),
    .stall_if(l1_stall_if), .stall_dm(l1_stall_dm)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_main_zero(input string tag);
    chk({tag, ".mem_en"},    32'(mem_en),    32'd0);
    chk({tag, ".mem_we"},    32'(mem_we),    32'd0);
    chk({tag, ".mem_addr"},  mem_addr,       32'd0);
    chk({tag, ".mem_wdata"}, mem_wdata,      32'd0);
    chk({tag, ".mem_type"},  32'(mem_type),  32'd0);
    chk({tag, ".if_valid"},  32'(if_valid),  32'd0);
    chk({tag, ".dm_valid"},  32'(dm_valid),  32'd0);
    chk({tag, ".if_rdata"},  if_rdata,       32'd0);
    chk({tag, ".dm_rdata"},  dm_rdata,       32'd0);
    chk({tag, ".stall_if"},  32'(stall_if),  32'd0);
    chk({tag, ".stall_dm"},  32'(stall_dm),  32'd0);
  endtask

  // Reference model: a schedule of when the single memory slot is next free and what it carries.
  int          next_free;
  int          en_cyc, val_cyc;
  logic        m_own_dm;
  logic        e_we;
  logic [31:0] e_addr, e_wdata;
  logic [2:0]  e_type;
  int          if_passed_over;
  logic        last_was_dm;

  initial begin
    int   k;
    int   rate;
    int   resets_done;
    logic exp_en, exp_ifv, exp_dmv, gdm;

    rst = 1'b1;
    if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0; dm_type = 0;
    mem_rdata = 0;
    l1_if_req = 0; l1_if_addr = 0; l1_dm_req = 0; l1_dm_we = 0; l1_dm_addr = 0;
    l1_dm_wdata = 0; l1_dm_type = 0; l1_mem_rdata = 0;
    tick(); tick();
    chk_main_zero("reset");
    chk("reset.l1_mem_en",   32'(l1_mem_en),   32'd0);
    chk("reset.l1_if_valid", 32'(l1_if_valid), 32'd0);
    chk("reset.l1_mem_addr", l1_mem_addr,      32'd0);
    rst = 1'b0;
    tick();

    // MEM_LAT=1 single fetch
    l1_if_req = 1'b1; l1_if_addr = 32'h0000_0040; l1_mem_rdata = 32'h1357_9BDF;
    #1 chk("l1_fetch.stall_if_c1", 32'(l1_stall_if), 32'd1);
    tick();
    chk("l1_fetch.mem_en",    32'(l1_mem_en),   32'd1);
    chk("l1_fetch.mem_we",    32'(l1_mem_we),   32'd0);
    chk("l1_fetch.mem_addr",  l1_mem_addr,      32'h40);
    chk("l1_fetch.if_valid0", 32'(l1_if_valid), 32'd0);
    chk("l1_fetch.stall_if2", 32'(l1_stall_if), 32'd1);
    tick();
    chk("l1_fetch.if_valid",  32'(l1_if_valid), 32'd1);
    chk("l1_fetch.if_rdata",  l1_if_rdata,      32'h1357_9BDF);
    chk("l1_fetch.mem_en_off",32'(l1_mem_en),   32'd0);
    chk("l1_fetch.stall_off", 32'(l1_stall_if), 32'd0);
    l1_if_req = 1'b0;
    tick();
    chk("l1_fetch.pulse_once",32'(l1_if_valid), 32'd0);

    // MEM_LAT=1 simultaneous store + fetch: DM first, IF in the next arbitration
    l1_if_req = 1'b1; l1_if_addr = 32'h0000_0044;
    l1_dm_req = 1'b1; l1_dm_we = 1'b1; l1_dm_addr = 32'h100; l1_dm_wdata = 32'hDEAD_BEEF;
    l1_dm_type = 3'd2;
    tick();
    chk("l1_both.mem_en",    32'(l1_mem_en),   32'd1);
    chk("l1_both.mem_we",    32'(l1_mem_we),   32'd1);
    chk("l1_both.mem_addr",  l1_mem_addr,      32'h100);
    chk("l1_both.mem_wdata", l1_mem_wdata,     32'hDEAD_BEEF);
    chk("l1_both.mem_type",  32'(l1_mem_type), 32'd2);
    tick();
    chk("l1_both.dm_valid",  32'(l1_dm_valid), 32'd1);
    chk("l1_both.if_valid0", 32'(l1_if_valid), 32'd0);
    l1_dm_req = 1'b0;
    tick();
    chk("l1_both.idle_gap",  32'(l1_mem_en),   32'd0);
    tick();
    chk("l1_both.if_en",     32'(l1_mem_en),   32'd1);
    chk("l1_both.if_addr",   l1_mem_addr,      32'h44);
    chk("l1_both.if_we",     32'(l1_mem_we),   32'd0);
    tick();
    chk("l1_both.if_valid",  32'(l1_if_valid), 32'd1);
    l1_if_req = 1'b0;

    // Randomized run on the MEM_LAT=3 instance; the cycle index k counts rising edges from here.
    k = 0; next_free = 0; en_cyc = -1; val_cyc = -1; m_own_dm = 1'b0;
    e_we = 0; e_addr = 0; e_wdata = 0; e_type = 0;
    if_passed_over = 0; last_was_dm = 1'b0; resets_done = 0;
    tick(); tick(); tick();
    while (k < NCYC) begin
      tick();
      k++;
      exp_en  = (k == en_cyc);
      exp_ifv = (k == val_cyc) && !m_own_dm;
      exp_dmv = (k == val_cyc) && m_own_dm;
      chk("rnd.mem_en",   32'(mem_en),   32'(exp_en));
      chk("rnd.if_valid", 32'(if_valid), 32'(exp_ifv));
      chk("rnd.dm_valid", 32'(dm_valid), 32'(exp_dmv));
      chk("rnd.stall_if", 32'(stall_if), 32'(if_req & ~exp_ifv));
      chk("rnd.stall_dm", 32'(stall_dm), 32'(dm_req & ~exp_dmv));
      if (exp_en) begin
        chk("rnd.mem_we",    32'(mem_we),   32'(e_we));
        chk("rnd.mem_addr",  mem_addr,      e_addr);
        chk("rnd.mem_wdata", mem_wdata,     e_wdata);
        chk("rnd.mem_type",  32'(mem_type), 32'(e_type));
      end
      if (exp_ifv) chk("rnd.if_rdata", if_rdata, mem_rdata);
      if (exp_dmv && !e_we) chk("rnd.dm_rdata", dm_rdata, mem_rdata);

      // Reset landing mid-WAIT: the access is abandoned with no pulse.
      if (k == en_cyc + 1 && resets_done < 2 && k > 700 * (resets_done + 1)) begin
        resets_done++;
        rst = 1'b1; if_req = 1'b0; dm_req = 1'b0;
        tick();
        k++;
        chk_main_zero("rst_wait");
        rst = 1'b0;
        en_cyc = -1; val_cyc = -1; next_free = k;
        if_passed_over = 0; last_was_dm = 1'b0;
        continue;
      end

      rate = (k < 1000) ? 40 : (k < 2000) ? 100 : 15;
      if (exp_ifv || !if_req) begin
        if_req  = ($urandom_range(99) < rate);
        if_addr = $urandom;
      end
      if (exp_dmv || !dm_req) begin
        dm_req   = ($urandom_range(99) < rate);
        dm_we    = 1'($urandom_range(1));
        dm_addr  = $urandom;
        dm_wdata = $urandom;
        dm_type  = 3'($urandom_range(7));
      end
      mem_rdata = $urandom;

      if (k >= next_free && (if_req || dm_req)) begin
`ifdef MEMARB_ROUND_ROBIN_EN
        gdm = dm_req && (!if_req || !last_was_dm);
        last_was_dm = gdm;
`else
        gdm = dm_req && (!if_req || if_passed_over < SMAX);
        if (!gdm) if_passed_over = 0;
        else if (if_req && if_passed_over < SMAX) if_passed_over++;
`endif
        m_own_dm = gdm;
        e_we    = gdm ? dm_we    : 1'b0;
        e_addr  = gdm ? dm_addr  : if_addr;
        e_wdata = gdm ? dm_wdata : 32'd0;
        e_type  = gdm ? dm_type  : 3'd0;
        en_cyc    = k + 1;
        val_cyc   = k + 1 + LAT;
        next_free = k + LAT + 2;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
